// File: rtl/bist_next_initiator.sv
// Controller side of the bist_next four-phase handshake: runs NUM_STEPS request/ack steps, flags done or timeout.
// bist_next follows start by one cycle; a slow responder only stretches the wait phases until TIMEOUT_CYCLES expires.
module bist_next_initiator #(
    parameter int NUM_STEPS      = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 2,
    localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic          bist_clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic          bist_next_ack,
    output logic          bist_next,
    output logic          busy,
    output logic          done,
    output logic          timeout_err,
    output logic [SW-1:0] step_idx,
    output logic          step_pulse
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [SW-1:0] LAST_IDX = SW'(NUM_STEPS - 1);
    localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, REQ, ACK_LOW, GAP, DONE, ERR} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] wait_cnt, wait_cnt_nxt, wait_inc;
    logic [GW-1:0] gap_cnt, gap_cnt_nxt;
    logic [SW-1:0] step_idx_nxt;
    logic          done_nxt, timeout_nxt, pulse_nxt, wait_expired;

    always_comb begin
        // Saturating wait counter: a stalled responder can never wrap it back under the limit.
        wait_inc     = (wait_cnt == '1) ? wait_cnt : wait_cnt + TW'(1);
        wait_expired = (TIMEOUT_CYCLES != 0) && (wait_inc == TO_LIM);
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        gap_cnt_nxt  = gap_cnt;
        step_idx_nxt = step_idx;
        done_nxt     = done;
        timeout_nxt  = timeout_err;
        pulse_nxt    = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start && !abort) begin
                    state_nxt    = REQ;
                    wait_cnt_nxt = '0;
                    step_idx_nxt = '0;
                    done_nxt     = 1'b0;
                    timeout_nxt  = 1'b0;
                end
            end
            REQ: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (bist_next_ack) begin
                    state_nxt    = ACK_LOW;
                    wait_cnt_nxt = '0;
                end else if (wait_expired) begin
                    state_nxt   = ERR;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_inc;
                end
            end
            ACK_LOW: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!bist_next_ack) begin
                    pulse_nxt = 1'b1;
                    if (step_idx == LAST_IDX) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        step_idx_nxt = step_idx + SW'(1);
                        if (GAP_CYCLES > 0) begin
                            state_nxt   = GAP;
                            gap_cnt_nxt = '0;
                        end else begin
                            state_nxt    = REQ;
                            wait_cnt_nxt = '0;
                        end
                    end
                end else if (wait_expired) begin
                    state_nxt   = ERR;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_inc;
                end
            end
            GAP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (gap_cnt == GAP_LAST) begin
                    state_nxt    = REQ;
                    wait_cnt_nxt = '0;
                end else begin
                    gap_cnt_nxt = gap_cnt + GW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge bist_clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            step_idx    <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            step_pulse  <= 1'b0;
            bist_next   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            step_idx    <= step_idx_nxt;
            done        <= done_nxt;
            timeout_err <= timeout_nxt;
            step_pulse  <= pulse_nxt;
            bist_next   <= (state_nxt == REQ);
            busy        <= (state_nxt == REQ) || (state_nxt == ACK_LOW) || (state_nxt == GAP);
        end
    end

endmodule

// File: tb/tb_bist_next_initiator.sv
// Bench for bist_next_initiator: delay-programmable responder, run-outcome model, pulse/end scoreboard.
module tb_bist_next_initiator;

    localparam int NS  = 4;
    localparam int TO  = 16;
    localparam int GAP = 2;

    logic       bist_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       bist_next_ack = 1'b0;
    logic       bist_next, busy, done, timeout_err, step_pulse;
    logic [1:0] step_idx;

    bist_next_initiator #(.NUM_STEPS(NS), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
        .bist_clk(bist_clk), .reset_n(reset_n), .start(start), .abort(abort),
        .bist_next_ack(bist_next_ack), .bist_next(bist_next), .busy(busy), .done(done),
        .timeout_err(timeout_err), .step_idx(step_idx), .step_pulse(step_pulse)
    );

    always #5 bist_clk = ~bist_clk;

    typedef struct {
        bit d;
        bit t;
        int idx;
    } end_t;

    int   pulse_q[$];
    end_t end_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   d1_arr[NS];
    int   d2_arr[NS];
    int   resp_k = 0;
    bit   gap_toggle = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Responder: raises ack d1 cycles after seeing the request, drops it d2 cycles after the request falls.
    int hi_cnt = 0;
    int lo_cnt = 0;
    bit glitch = 1'b0;
    always @(posedge bist_clk) begin
        #1;
        if (!busy) begin
            bist_next_ack = 1'b0;
            hi_cnt = 0;
            lo_cnt = 0;
            glitch = 1'b0;
        end else if (glitch) begin
            bist_next_ack = 1'b0;
            glitch = 1'b0;
        end else if (gap_toggle && step_pulse) begin
            bist_next_ack = 1'b1;
            glitch = 1'b1;
        end else if (bist_next && !bist_next_ack) begin
            hi_cnt++;
            lo_cnt = 0;
            if (hi_cnt > d1_arr[resp_k]) begin
                bist_next_ack = 1'b1;
                hi_cnt = 0;
            end
        end else if (!bist_next && bist_next_ack) begin
            lo_cnt++;
            if (lo_cnt > d2_arr[resp_k]) begin
                bist_next_ack = 1'b0;
                lo_cnt = 0;
                if (resp_k < NS - 1) resp_k++;
            end
        end else begin
            hi_cnt = 0;
            lo_cnt = 0;
        end
    end

    // Monitor: a pulse reports the step held in the cycle before it; busy falling closes a run.
    logic       busy_prev = 1'b0;
    logic [1:0] idx_prev = 2'd0;
    always @(negedge bist_clk) begin : mon
        int   e;
        end_t ee;
        if (step_pulse === 1'b1) begin
            if (pulse_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: step %0d pulsed, no pulse expected", idx_prev);
            end else begin
                e = pulse_q.pop_front();
                chk("pulse_step", 32'(idx_prev), e);
            end
        end
        if (busy_prev === 1'b1 && busy === 1'b0) begin
            if (end_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_run_end: done=%0d err=%0d", done, timeout_err);
            end else begin
                ee = end_q.pop_front();
                chk("end_done", 32'(done), 32'(ee.d));
                chk("end_timeout_err", 32'(timeout_err), 32'(ee.t));
                chk("end_step_idx", 32'(step_idx), ee.idx);
            end
        end
        busy_prev = busy;
        idx_prev  = step_idx;
    end

    task automatic set_delays(input int a, input int b);
        for (int k = 0; k < NS; k++) begin
            d1_arr[k] = a;
            d2_arr[k] = b;
        end
    endtask

    // A run completes step k only if both wait phases finish within TO cycles.
    task automatic push_model();
        bit   failed = 1'b0;
        end_t e;
        for (int k = 0; k < NS && !failed; k++) begin
            if (d1_arr[k] >= TO || d2_arr[k] >= TO) begin
                e.d = 1'b0; e.t = 1'b1; e.idx = k;
                end_q.push_back(e);
                failed = 1'b1;
            end else begin
                pulse_q.push_back(k);
            end
        end
        if (!failed) begin
            e.d = 1'b1; e.t = 1'b0; e.idx = NS - 1;
            end_q.push_back(e);
        end
    endtask

    task automatic run_watch(input int mid_start, output int first_hi, output int min_low);
        int lo_run = 0;
        bit in_first = 1'b1;
        bit finished = 1'b0;
        first_hi = 0;
        min_low = 9999;
        resp_k = 0;
        start = 1'b1;
        @(negedge bist_clk);
        start = 1'b0;
        chk("start_latency_bist_next", 32'(bist_next), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_clears_done", 32'(done), 0);
        chk("start_clears_err", 32'(timeout_err), 0);
        chk("start_step_idx", 32'(step_idx), 0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            if (bist_next) begin
                if (lo_run > 0 && lo_run < min_low) min_low = lo_run;
                lo_run = 0;
                if (in_first) first_hi++;
            end else begin
                in_first = 1'b0;
                lo_run++;
            end
            start = (cyc == mid_start);
            @(negedge bist_clk);
        end
        start = 1'b0;
        if (!finished) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: busy=%0d after 3000 cycles, required 0", busy);
        end
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int   fh, ml;
        bit   found;
        end_t e;
        set_delays(1, 1);
        repeat (3) @(negedge bist_clk);
        chk("rst_bist_next", 32'(bist_next), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_step_idx", 32'(step_idx), 0);
        chk("rst_step_pulse", 32'(step_pulse), 0);
        reset_n = 1'b1;
        @(negedge bist_clk);

        // Nominal run
        push_model();
        run_watch(-1, fh, ml);
        chk("nom_first_req_cycles", fh, 2);
        chk("nom_low_between_reqs", ml, 2 + GAP);
        chk("nom_done", 32'(done), 1);
        chk("nom_busy", 32'(busy), 0);

        // Restart after done, with a start while busy and ack toggling during GAP
        gap_toggle = 1'b1;
        push_model();
        run_watch(7, fh, ml);
        gap_toggle = 1'b0;
        chk("restart_low_between_reqs", ml, 2 + GAP);
        chk("restart_done", 32'(done), 1);

        // abort while idle is ignored, and beats a simultaneous start
        abort = 1'b1;
        @(negedge bist_clk);
        abort = 1'b0;
        chk("idle_abort_done_kept", 32'(done), 1);
        abort = 1'b1;
        start = 1'b1;
        @(negedge bist_clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_busy", 32'(busy), 0);
        chk("abort_start_bist_next", 32'(bist_next), 0);
        chk("abort_start_done_kept", 32'(done), 1);

        // Request never acknowledged
        set_delays(1000, 1);
        push_model();
        run_watch(-1, fh, ml);
        chk("to_req_cycles", fh, TO);
        chk("to_err", 32'(timeout_err), 1);
        chk("to_bist_next", 32'(bist_next), 0);

        // Ack stuck high
        set_delays(1, 1000);
        push_model();
        run_watch(-1, fh, ml);
        chk("stuck_first_req_cycles", fh, 2);
        chk("stuck_err", 32'(timeout_err), 1);
        chk("stuck_step_idx", 32'(step_idx), 0);

        // Abort during step 2
        set_delays(1, 1);
        pulse_q.push_back(0);
        pulse_q.push_back(1);
        e.d = 1'b0; e.t = 1'b0; e.idx = 2;
        end_q.push_back(e);
        resp_k = 0;
        start = 1'b1;
        @(negedge bist_clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bist_next && step_idx == 2'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge bist_clk);
        end
        chk("abort_reached_step2", 32'(found), 1);
        abort = 1'b1;
        @(negedge bist_clk);
        abort = 1'b0;
        chk("abort_bist_next", 32'(bist_next), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_err", 32'(timeout_err), 0);
        chk("abort_step_idx", 32'(step_idx), 2);
        push_model();
        run_watch(-1, fh, ml);

        // Synchronous reset in REQ, with start held alongside it
        e.d = 1'b0; e.t = 1'b0; e.idx = 0;
        end_q.push_back(e);
        resp_k = 0;
        start = 1'b1;
        @(negedge bist_clk);
        start = 1'b0;
        chk("pre_reset_in_req", 32'(bist_next), 1);
        reset_n = 1'b0;
        start = 1'b1;
        @(negedge bist_clk);
        chk("srst_bist_next", 32'(bist_next), 0);
        chk("srst_busy", 32'(busy), 0);
        chk("srst_done", 32'(done), 0);
        chk("srst_err", 32'(timeout_err), 0);
        chk("srst_step_idx", 32'(step_idx), 0);
        chk("srst_step_pulse", 32'(step_pulse), 0);
        reset_n = 1'b1;
        start = 1'b0;
        @(negedge bist_clk);
        chk("srst_start_ignored", 32'(busy), 0);
        push_model();
        run_watch(-1, fh, ml);
        chk("post_reset_done", 32'(done), 1);

        // Randomized responder latencies, including the timeout boundary
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < NS; k++) begin
                d1_arr[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
                d2_arr[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            end
            gap_toggle = ($urandom_range(0, 1) == 1);
            push_model();
            run_watch(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : -1, fh, ml);
            gap_toggle = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge bist_clk);
        end

        repeat (4) @(negedge bist_clk);
        chk("pulse_queue_drained", pulse_q.size(), 0);
        chk("end_queue_drained", end_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
